// File: rtl/disp_scan6_if.sv
// Bus between the hh:mm:ss counter chain and the six-digit 7-segment display driver.
//   sec, min, hour : 6-bit binary counts from the 0..59 counter stages
//   seg            : segments {g,f,e,d,c,b,a}, active-high
//   dig_sel        : one-hot digit enable, bit0 = rightmost digit
//   dp             : decimal-point / colon segment
// master = counter side (drives counts), slave = display driver (drives segments).
interface disp_scan6_if;
  logic [5:0] sec;
  logic [5:0] min;
  logic [5:0] hour;
  logic [6:0] seg;
  logic [5:0] dig_sel;
  logic       dp;

  modport master (
    output sec, min, hour,
    input  seg, dig_sel, dp
  );

  modport slave (
    input  sec, min, hour,
    output seg, dig_sel, dp
  );
endinterface

// File: rtl/disp_scan6.sv
// disp_scan6 : six-digit multiplexed 7-segment driver for an hh:mm:ss clock.
// Snapshots sec/min/hour once per frame, splits each into BCD tens/ones and
// scans them onto a shared segment bus, blanking the first BLANK cycles of
// every digit slot to suppress ghosting.
// Ports:
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   bus_if  : disp_scan6_if.slave (sec/min/hour in, seg/dig_sel/dp out)
// Parameters:
//   SCAN_DIV : clk cycles per digit slot (2..2^20)
//   BLANK    : blank cycles at the start of each slot (1..SCAN_DIV-1)
// Build option:
//   COLON_BLINK_EN : when defined, dp lights during the lit part of digits
//                    2 and 4 whenever the captured seconds value is even.
module disp_scan6 #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned BLANK    = 2
) (
  input logic         clk,
  input logic         rst_n,
  disp_scan6_if.slave bus_if
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned VAL_W = 6;
  localparam int unsigned SEG_W = 7;
  localparam int unsigned DIG_N = 6;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIG_N - 1);
  localparam logic [VAL_W-1:0] VAL_LIMIT = VAL_W'(60);
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'h40;

  // Slot/digit position and frame snapshot
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [VAL_W-1:0] sec_q, sec_d;
  logic [VAL_W-1:0] min_q, min_d;
  logic [VAL_W-1:0] hour_q, hour_d;

  // Registered display outputs
  logic [SEG_W-1:0] seg_q, seg_d;
  logic [DIG_N-1:0] dig_q, dig_d;
  logic             dp_q, dp_d;

  // Decode helpers
  logic             frame_start_c;
  logic             slot_end_c;
  logic             lit_c;
  logic [VAL_W-1:0] pair_val_c;
  logic [3:0]       tens_c;
  logic [3:0]       ones_c;
  logic [3:0]       digit_c;

  // BCD digit to gfedcba pattern
  function automatic logic [SEG_W-1:0] seg_code(input logic [3:0] d);
    logic [SEG_W-1:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  // Tens digit of a 0..59 value by range compare, avoiding a divider
  function automatic logic [3:0] tens_of(input logic [VAL_W-1:0] v);
    logic [3:0] t;
    if      (v >= VAL_W'(50)) t = 4'd5;
    else if (v >= VAL_W'(40)) t = 4'd4;
    else if (v >= VAL_W'(30)) t = 4'd3;
    else if (v >= VAL_W'(20)) t = 4'd2;
    else if (v >= VAL_W'(10)) t = 4'd1;
    else                      t = 4'd0;
    return t;
  endfunction

  // Ones digit given the already-computed tens digit
  function automatic logic [3:0] ones_of(input logic [VAL_W-1:0] v,
                                         input logic [3:0]       t);
    logic [VAL_W-1:0] base;
    logic [VAL_W-1:0] rem;
    base = VAL_W'({2'b00, t} * VAL_W'(10));
    rem  = v - base;
    return rem[3:0];
  endfunction

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      sec_q  <= '0;
      min_q  <= '0;
      hour_q <= '0;
      seg_q  <= '0;
      dig_q  <= '0;
      dp_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      sec_q  <= sec_d;
      min_q  <= min_d;
      hour_q <= hour_d;
      seg_q  <= seg_d;
      dig_q  <= dig_d;
      dp_q   <= dp_d;
    end
  end

  // Scan position, frame snapshot and next output values
  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    sec_d  = sec_q;
    min_d  = min_q;
    hour_d = hour_q;
    seg_d  = '0;
    dig_d  = '0;
    dp_d   = 1'b0;

    frame_start_c = (cnt_q == '0) && (idx_q == '0);
    slot_end_c    = (cnt_q == CNT_LAST);
    lit_c         = (cnt_q >= CNT_BLANK);

    if (slot_end_c) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Capture the whole time once per frame so a counter tick cannot tear it
    if (frame_start_c) begin
      sec_d  = bus_if.sec;
      min_d  = bus_if.min;
      hour_d = bus_if.hour;
    end

    case (idx_q[2:1])
      2'd0:    pair_val_c = sec_q;
      2'd1:    pair_val_c = min_q;
      default: pair_val_c = hour_q;
    endcase

    tens_c  = tens_of(pair_val_c);
    ones_c  = ones_of(pair_val_c, tens_c);
    digit_c = idx_q[0] ? tens_c : ones_c;

    if (lit_c) begin
      seg_d = (pair_val_c >= VAL_LIMIT) ? SEG_DASH : seg_code(digit_c);
      dig_d = DIG_N'(1) << idx_q;
`ifdef COLON_BLINK_EN
      // Separators sit after the minutes-ones and hours-ones digits
      dp_d  = ((idx_q == IDX_W'(2)) || (idx_q == IDX_W'(4))) && !sec_q[0];
`else
      dp_d  = 1'b0;
`endif
    end
  end

  assign bus_if.seg     = seg_q;
  assign bus_if.dig_sel = dig_q;
  assign bus_if.dp      = dp_q;

endmodule
